int_sequencer: RTL

- Controller that sequences the 6502 interrupt and reset entry: stack pushes of PCH, PCL and P, vector fetch, and the PC load.
- Sits between the instruction decoder/bus interface and the CPU register set (PC, SP, P).
- Drives the address/data bus and the register load/decrement strobes while active.
- Arbitrates between reset, NMI, IRQ and BRK requests.

---
 rtl/int_sequencer_if.sv | 25 ++
 rtl/int_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/int_sequencer_if.sv
// rtl/int_sequencer_if.sv - bus and register-file signals between the interrupt sequencer and the core
interface int_sequencer_if;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic [7:0]  data_in;
    logic        rw;
    logic        sp_dec;
    logic        set_i;
    logic        pc_load;
    logic [15:0] pc_out;
    logic        seq_busy;
    logic [15:0] pc_in;
    logic [7:0]  p_in;
    logic [7:0]  sp_in;

    modport master (
        output addr, data_out, rw, sp_dec, set_i, pc_load, pc_out, seq_busy,
        input  data_in, pc_in, p_in, sp_in
    );

    modport slave (
        input  addr, data_out, rw, sp_dec, set_i, pc_load, pc_out, seq_busy,
        output data_in, pc_in, p_in, sp_in
    );
endinterface

// File: rtl/int_sequencer.sv
// rtl/int_sequencer.sv - 6502 reset/NMI/IRQ/BRK entry sequencer; optional INT_SEQ_NMI_HIJACK_EN lets a late NMI take over an IRQ/BRK vector
module int_sequencer #(
    parameter logic [7:0]  STACK_PAGE = 8'h01,
    parameter logic [15:0] VEC_NMI    = 16'hFFFA,
    parameter logic [15:0] VEC_RST    = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ    = 16'hFFFE
) (
    input  logic clk,
    input  logic rst,
    input  logic nmi_n,
    input  logic irq_n,
    input  logic brk_req,
    input  logic instr_done,
    input  logic i_flag,
    int_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH_H, S_PUSH_L, S_PUSH_P, S_VEC_LO, S_VEC_HI, S_LOAD
    } state_t;

    typedef enum logic [1:0] {
        SRC_RST, SRC_NMI, SRC_IRQ, SRC_BRK
    } src_t;

    state_t      state, state_nx;
    src_t        src, src_nx;
    logic        rst_pend;
    logic        nmi_pend;
    logic        nmi_prev;
    logic        nmi_clr;
    logic [7:0]  vec_lo;
    logic [7:0]  vec_hi;
    logic [15:0] pc_hold;
    logic [15:0] vec_base;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            src      <= SRC_RST;
            rst_pend <= 1'b1;
            nmi_pend <= 1'b0;
            nmi_prev <= 1'b1;
            vec_lo   <= 8'h00;
            vec_hi   <= 8'h00;
            pc_hold  <= 16'h0000;
        end else begin
            state    <= state_nx;
            src      <= src_nx;
            nmi_prev <= nmi_n;
            // a fresh falling edge wins over a clear in the same cycle
            nmi_pend <= (nmi_prev & ~nmi_n) | (nmi_pend & ~nmi_clr);
            if (state == S_VEC_LO)
                vec_lo <= bus.data_in;
            if (state == S_VEC_HI)
                vec_hi <= bus.data_in;
            if (state == S_LOAD) begin
                pc_hold <= {vec_hi, vec_lo};
                if (src == SRC_RST)
                    rst_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        src_nx   = src;
        nmi_clr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (rst_pend) begin
                    state_nx = S_PUSH_H;
                    src_nx   = SRC_RST;
                end else if (instr_done) begin
                    if (nmi_pend) begin
                        state_nx = S_PUSH_H;
                        src_nx   = SRC_NMI;
                        nmi_clr  = 1'b1;
                    end else if (!irq_n && !i_flag) begin
                        state_nx = S_PUSH_H;
                        src_nx   = SRC_IRQ;
                    end else if (brk_req) begin
                        state_nx = S_PUSH_H;
                        src_nx   = SRC_BRK;
                    end
                end
            end
            S_PUSH_H: state_nx = S_PUSH_L;
            S_PUSH_L: state_nx = S_PUSH_P;
            S_PUSH_P: begin
                state_nx = S_VEC_LO;
`ifdef INT_SEQ_NMI_HIJACK_EN
                // B has already been pushed, so only the vector follows the NMI
                if (nmi_pend && (src == SRC_IRQ || src == SRC_BRK)) begin
                    src_nx  = SRC_NMI;
                    nmi_clr = 1'b1;
                end
`endif
            end
            S_VEC_LO: state_nx = S_VEC_HI;
            S_VEC_HI: state_nx = S_LOAD;
            S_LOAD:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        case (src)
            SRC_RST: vec_base = VEC_RST;
            SRC_NMI: vec_base = VEC_NMI;
            default: vec_base = VEC_IRQ;
        endcase
    end

    always_comb begin
        bus.addr     = 16'h0000;
        bus.data_out = 8'h00;
        bus.rw       = 1'b1;
        bus.sp_dec   = 1'b0;
        bus.set_i    = 1'b0;
        bus.pc_load  = 1'b0;
        bus.pc_out   = pc_hold;
        bus.seq_busy = (state != S_IDLE);
        case (state)
            S_PUSH_H, S_PUSH_L, S_PUSH_P: begin
                bus.addr   = {STACK_PAGE, bus.sp_in};
                bus.sp_dec = 1'b1;
                // reset performs the pushes as dummy reads
                bus.rw     = (src == SRC_RST);
                if (state == S_PUSH_H)
                    bus.data_out = bus.pc_in[15:8];
                else if (state == S_PUSH_L)
                    bus.data_out = bus.pc_in[7:0];
                else
                    bus.data_out = {bus.p_in[7:6], 1'b1, src == SRC_BRK, bus.p_in[3:0]};
            end
            S_VEC_LO: begin
                bus.addr  = vec_base;
                bus.set_i = 1'b1;
            end
            S_VEC_HI: bus.addr = vec_base + 16'h0001;
            S_LOAD: begin
                bus.pc_load = 1'b1;
                bus.pc_out  = {vec_hi, vec_lo};
            end
            default: ;
        endcase
    end

endmodule
